// File: rtl/fovea_param_scheduler_pkg.sv
// Shared types and constants for the foveated decoder parameter scheduler.
// Optional build macro: GAZE_SMOOTH_EN.
package fovea_pkg;

    localparam int GAZE_W   = 11;
    localparam int RADIUS_W = 12;
    localparam int THRES_W  = 24;

    localparam int H_ACTIVE_DEF     = 1920;
    localparam int V_ACTIVE_DEF     = 1080;
    localparam int STALE_FRAMES_DEF = 8;

    localparam logic [GAZE_W-1:0] CENTRE_X_DEF = GAZE_W'(H_ACTIVE_DEF / 2);
    localparam logic [GAZE_W-1:0] CENTRE_Y_DEF = GAZE_W'(V_ACTIVE_DEF / 2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_LATCH,
        S_SQ0,
        S_SQ1,
        S_SQ2,
        S_WAIT_RDY,
        S_COMMIT
    } state_t;

endpackage

// File: rtl/fovea_param_scheduler_if.sv
// Gaze sample stream from the eye tracker: valid/ready handshake.
// The tracker side is the master, the scheduler the slave.
interface fovea_param_scheduler_if;
    import fovea_pkg::*;

    logic              valid;
    logic [GAZE_W-1:0] x;
    logic [GAZE_W-1:0] y;
    logic              ready;

    modport master (output valid, output x, output y, input ready);
    modport slave  (input valid, input x, input y, output ready);

endinterface

// File: rtl/fovea_param_scheduler_squarer.sv
// Registered unsigned squarer, one-cycle latency.
// Time-shared by the scheduler across the three radii.
module fovea_squarer
    import fovea_pkg::*;
(
    input  logic                i_clk,
    input  logic [RADIUS_W-1:0] a,
    output logic [THRES_W-1:0]  sq
);

    always_ff @(posedge i_clk) begin
        sq <= a * a;
    end

endmodule

// File: rtl/fovea_param_scheduler.sv
// Frame-synchronous gaze/threshold parameter scheduler for the foveated decoder.
// Build macro GAZE_SMOOTH_EN enables 2-tap averaging of accepted gaze samples.
module fovea_param_scheduler
    import fovea_pkg::*;
#(
    parameter int H_ACTIVE     = H_ACTIVE_DEF,
    parameter int V_ACTIVE     = V_ACTIVE_DEF,
    parameter int STALE_FRAMES = STALE_FRAMES_DEF
) (
    input  logic                i_clk,
    input  logic                i_rst,
    fovea_param_scheduler_if.slave gaze,
    input  logic [RADIUS_W-1:0] i_radius_1,
    input  logic [RADIUS_W-1:0] i_radius_2,
    input  logic [RADIUS_W-1:0] i_radius_3,
    input  logic                i_sof,
    input  logic                i_param_ready,
    output logic [GAZE_W-1:0]   o_gaze_x,
    output logic [GAZE_W-1:0]   o_gaze_y,
    output logic [THRES_W-1:0]  o_thres_1,
    output logic [THRES_W-1:0]  o_thres_2,
    output logic [THRES_W-1:0]  o_thres_3,
    output logic                o_update,
    output logic                o_stale
);

    localparam logic [GAZE_W-1:0] X_MAX = GAZE_W'(H_ACTIVE - 1);
    localparam logic [GAZE_W-1:0] Y_MAX = GAZE_W'(V_ACTIVE - 1);
    localparam logic [GAZE_W-1:0] CX    = GAZE_W'(H_ACTIVE / 2);
    localparam logic [GAZE_W-1:0] CY    = GAZE_W'(V_ACTIVE / 2);
    localparam int                CNT_W = $clog2(STALE_FRAMES + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(STALE_FRAMES);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(STALE_FRAMES - 1);

    state_t              state;
    logic                sof_q;
    logic                sof_rise;
    logic                accept;
    logic [GAZE_W-1:0]   cx;
    logic [GAZE_W-1:0]   cy;
    logic [GAZE_W-1:0]   nx;
    logic [GAZE_W-1:0]   ny;
    logic [GAZE_W-1:0]   pend_x;
    logic [GAZE_W-1:0]   pend_y;
    logic [GAZE_W-1:0]   sh_x;
    logic [GAZE_W-1:0]   sh_y;
    logic [RADIUS_W-1:0] sh_r2;
    logic [RADIUS_W-1:0] sh_r3;
    logic [THRES_W-1:0]  sh_t1;
    logic [THRES_W-1:0]  sh_t2;
    logic [THRES_W-1:0]  sh_t3;
    logic [RADIUS_W-1:0] sq_in;
    logic [THRES_W-1:0]  sq_q;
    logic [CNT_W-1:0]    stale_cnt;
    logic                acc_since;
    logic                idle_frame;
    logic                stale_hit;

    assign sof_rise   = i_sof && !sof_q;
    assign gaze.ready = (state != S_IDLE) && (state != S_LATCH);
    assign accept     = gaze.valid && gaze.ready;
    assign cx         = (gaze.x > X_MAX) ? X_MAX : gaze.x;
    assign cy         = (gaze.y > Y_MAX) ? Y_MAX : gaze.y;
    assign idle_frame = sof_rise && !accept && !acc_since;
    assign stale_hit  = idle_frame && (stale_cnt == CNT_LAST);

`ifdef GAZE_SMOOTH_EN
    logic              have;
    logic [GAZE_W:0]   sum_x;
    logic [GAZE_W:0]   sum_y;

    assign sum_x = {1'b0, pend_x} + {1'b0, cx} + (GAZE_W+1)'(1);
    assign sum_y = {1'b0, pend_y} + {1'b0, cy} + (GAZE_W+1)'(1);
    // A fresh track (post-reset or after timeout) has no history to blend with.
    assign nx    = (have && !o_stale) ? sum_x[GAZE_W:1] : cx;
    assign ny    = (have && !o_stale) ? sum_y[GAZE_W:1] : cy;

    always_ff @(posedge i_clk) begin
        if (i_rst)       have <= 1'b0;
        else if (accept) have <= 1'b1;
    end
`else
    assign nx = cx;
    assign ny = cy;
`endif

    // Feed the squarer one state early so each result lands as SQn retires.
    always_comb begin
        sq_in = i_radius_1;
        unique case (state)
            S_SQ0:   sq_in = sh_r2;
            S_SQ1:   sq_in = sh_r3;
            default: sq_in = i_radius_1;
        endcase
    end

    fovea_squarer u_sq (
        .i_clk (i_clk),
        .a     (sq_in),
        .sq    (sq_q)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= S_IDLE;
            sof_q     <= 1'b0;
            pend_x    <= CX;
            pend_y    <= CY;
            sh_x      <= CX;
            sh_y      <= CY;
            sh_r2     <= '0;
            sh_r3     <= '0;
            sh_t1     <= '0;
            sh_t2     <= '0;
            sh_t3     <= '0;
            stale_cnt <= '0;
            acc_since <= 1'b0;
            o_gaze_x  <= CX;
            o_gaze_y  <= CY;
            o_thres_1 <= '0;
            o_thres_2 <= '0;
            o_thres_3 <= '0;
            o_update  <= 1'b0;
            o_stale   <= 1'b0;
        end else begin
            sof_q    <= i_sof;
            o_update <= 1'b0;

            if (accept) begin
                pend_x    <= nx;
                pend_y    <= ny;
                stale_cnt <= '0;
                o_stale   <= 1'b0;
            end else if (stale_hit) begin
                pend_x    <= CX;
                pend_y    <= CY;
                stale_cnt <= CNT_MAX;
                o_stale   <= 1'b1;
            end else if (idle_frame && stale_cnt != CNT_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
            end

            if (sof_rise)    acc_since <= 1'b0;
            else if (accept) acc_since <= 1'b1;

            unique case (state)
                S_IDLE: state <= S_ARM;
                S_ARM: begin
                    if (sof_rise) state <= S_LATCH;
                end
                S_LATCH: begin
                    sh_x  <= pend_x;
                    sh_y  <= pend_y;
                    sh_r2 <= i_radius_2;
                    sh_r3 <= i_radius_3;
                    state <= S_SQ0;
                end
                S_SQ0: begin
                    sh_t1 <= sq_q;
                    state <= S_SQ1;
                end
                S_SQ1: begin
                    sh_t2 <= sq_q;
                    state <= S_SQ2;
                end
                S_SQ2: begin
                    sh_t3 <= sq_q;
                    state <= S_WAIT_RDY;
                end
                S_WAIT_RDY: begin
                    if (i_param_ready) begin
                        o_gaze_x  <= sh_x;
                        o_gaze_y  <= sh_y;
                        o_thres_1 <= sh_t1;
                        o_thres_2 <= sh_t2;
                        o_thres_3 <= sh_t3;
                        o_update  <= 1'b1;
                        state     <= S_COMMIT;
                    end
                end
                S_COMMIT: state <= S_ARM;
                default:  state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fovea_param_scheduler.sv
// Directed table-driven bench for fovea_param_scheduler.
// Also checks wait/ignore, stale timeout, mid-op reset and smoothing.
module tb_fovea_param_scheduler;

    logic        i_clk;
    logic        i_rst;
    logic [11:0] i_radius_1;
    logic [11:0] i_radius_2;
    logic [11:0] i_radius_3;
    logic        i_sof;
    logic        i_param_ready;
    logic [10:0] o_gaze_x;
    logic [10:0] o_gaze_y;
    logic [23:0] o_thres_1;
    logic [23:0] o_thres_2;
    logic [23:0] o_thres_3;
    logic        o_update;
    logic        o_stale;

    fovea_param_scheduler_if gif ();

    fovea_param_scheduler dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .gaze          (gif),
        .i_radius_1    (i_radius_1),
        .i_radius_2    (i_radius_2),
        .i_radius_3    (i_radius_3),
        .i_sof         (i_sof),
        .i_param_ready (i_param_ready),
        .o_gaze_x      (o_gaze_x),
        .o_gaze_y      (o_gaze_y),
        .o_thres_1     (o_thres_1),
        .o_thres_2     (o_thres_2),
        .o_thres_3     (o_thres_3),
        .o_update      (o_update),
        .o_stale       (o_stale)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [10:0] gx;
        logic [10:0] gy;
        logic [11:0] r1;
        logic [11:0] r2;
        logic [11:0] r3;
        logic [10:0] ex;
        logic [10:0] ey;
        logic [23:0] t1;
        logic [23:0] t2;
        logic [23:0] t3;
    } vec_t;

    vec_t tbl [5];
    int   n_tests;
    int   n_fail;
    int   mx;
    int   my;
    int   have_m;

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic send(input int x, input int y);
        int cx;
        int cy;
        cx = (x > 1919) ? 1919 : x;
        cy = (y > 1079) ? 1079 : y;
`ifdef GAZE_SMOOTH_EN
        if (have_m != 0) begin
            cx = (mx + cx + 1) >> 1;
            cy = (my + cy + 1) >> 1;
        end
`endif
        mx = cx;
        my = cy;
        have_m = 1;
        gif.valid = 1'b1;
        gif.x = 11'(x);
        gif.y = 11'(y);
        step();
        gif.valid = 1'b0;
    endtask

    task automatic frame(output int lat);
        step();
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        lat = 0;
        while (!o_update && lat < 60) begin
            step();
            lat++;
        end
        if (!o_update) lat = -1;
    endtask

    task automatic chk_out(string tag, int ex, int ey);
        chk({tag, " gaze_x"}, 32'(o_gaze_x), 32'(ex));
        chk({tag, " gaze_y"}, 32'(o_gaze_y), 32'(ey));
    endtask

    initial begin
        int lat;
        int ups;
        int ex;
        int ey;
        n_tests = 0;
        n_fail  = 0;
        mx = 960;
        my = 540;
        have_m = 0;

        tbl[0] = '{100, 200, 300, 200, 100, 100, 200, 90000, 40000, 10000};
        tbl[1] = '{2047, 1500, 4095, 0, 1, 1919, 1079, 16769025, 0, 1};
        tbl[2] = '{1919, 1079, 1000, 500, 250, 1919, 1079, 1000000, 250000, 62500};
        tbl[3] = '{0, 0, 2048, 1024, 512, 0, 0, 4194304, 1048576, 262144};
        tbl[4] = '{1920, 1080, 10, 3, 7, 1919, 1079, 100, 9, 49};

        i_rst = 1'b1;
        i_sof = 1'b0;
        i_param_ready = 1'b1;
        i_radius_1 = '0;
        i_radius_2 = '0;
        i_radius_3 = '0;
        gif.valid = 1'b0;
        gif.x = '0;
        gif.y = '0;
        repeat (3) step();
        chk_out("reset", 960, 540);
        chk("reset thres_1", 32'(o_thres_1), 0);
        chk("reset thres_2", 32'(o_thres_2), 0);
        chk("reset thres_3", 32'(o_thres_3), 0);
        chk("reset update", 32'(o_update), 0);
        chk("reset stale", 32'(o_stale), 0);
        chk("reset ready", 32'(gif.ready), 0);
        i_rst = 1'b0;
        step();
        chk("ready in arm", 32'(gif.ready), 1);

        for (int i = 0; i < 5; i++) begin
            i_radius_1 = tbl[i].r1;
            i_radius_2 = tbl[i].r2;
            i_radius_3 = tbl[i].r3;
            send(tbl[i].gx, tbl[i].gy);
            frame(lat);
`ifdef GAZE_SMOOTH_EN
            ex = mx;
            ey = my;
`else
            ex = tbl[i].ex;
            ey = tbl[i].ey;
`endif
            chk($sformatf("vec%0d latency", i), 32'(lat), 5);
            chk_out($sformatf("vec%0d", i), ex, ey);
            chk($sformatf("vec%0d thres_1", i), 32'(o_thres_1), 32'(tbl[i].t1));
            chk($sformatf("vec%0d thres_2", i), 32'(o_thres_2), 32'(tbl[i].t2));
            chk($sformatf("vec%0d thres_3", i), 32'(o_thres_3), 32'(tbl[i].t3));
            step();
            chk($sformatf("vec%0d update width", i), 32'(o_update), 0);
        end

        // Decoder busy: commit must wait, second SOF ignored.
        ex = mx;
        ey = my;
        i_param_ready = 1'b0;
        i_radius_1 = 30;
        i_radius_2 = 20;
        i_radius_3 = 10;
        send(300, 400);
        step();
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        ups = 0;
        for (int c = 0; c < 20; c++) begin
            i_sof = (c == 8);
            step();
            if (o_update) ups++;
        end
        i_sof = 1'b0;
        chk("wait no update", 32'(ups), 0);
        chk_out("wait held", ex, ey);
        i_param_ready = 1'b1;
        step();
        chk("wait release update", 32'(o_update), 1);
        chk_out("wait commit", mx, my);
        chk("wait thres_1", 32'(o_thres_1), 900);
        chk("wait thres_3", 32'(o_thres_3), 100);
        ups = 0;
        for (int c = 0; c < 12; c++) begin
            step();
            if (o_update) ups++;
        end
        chk("no extra commit", 32'(ups), 0);

        // Stale timeout after STALE_FRAMES gaze-less frames.
        send(700, 700);
        ex = mx;
        ey = my;
        frame(lat);
        chk("stale base latency", 32'(lat), 5);
        for (int f = 1; f <= 8; f++) begin
            frame(lat);
            if (f == 7) begin
                chk("stale at 7", 32'(o_stale), 0);
                chk_out("stale 7 gaze", ex, ey);
            end
        end
        chk("stale at 8", 32'(o_stale), 1);
        chk_out("stale centre", 960, 540);
        send(500, 500);
        chk("stale cleared", 32'(o_stale), 0);
        frame(lat);
        chk_out("post stale", 500, 500);

        // Reset while a commit is pending in WAIT_RDY.
        i_param_ready = 1'b0;
        send(50, 60);
        step();
        i_sof = 1'b1;
        step();
        i_sof = 1'b0;
        repeat (6) step();
        i_rst = 1'b1;
        repeat (2) step();
        chk_out("midreset", 960, 540);
        chk("midreset thres_1", 32'(o_thres_1), 0);
        chk("midreset ready", 32'(gif.ready), 0);
        i_rst = 1'b0;
        i_param_ready = 1'b1;
        have_m = 0;
        step();

        // Smoothing: pending 100 then sample 201.
        send(100, 100);
        frame(lat);
        chk_out("smooth first", 100, 100);
        send(201, 201);
        frame(lat);
`ifdef GAZE_SMOOTH_EN
        chk_out("smooth avg", 151, 151);
`else
        chk_out("smooth off", 201, 201);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fovea_param_scheduler.md
# fovea_param_scheduler

Frame-synchronous parameter scheduler for the foveated decoder. It accepts gaze samples from the eye-tracker stream, clamps them (and optionally smooths them), and squares the three configured foveal radii into distance-squared thresholds. It commits a coherent parameter set (gaze x/y, thres 1..3) to the decoder once per frame, only after a frame start and only while the decoder reports parameter-ready, so parameters never change mid-frame.

## Interface
- H_ACTIVE, 1920, active pixels per line; gaze x clamp bound.
- V_ACTIVE, 1080, active lines per frame; gaze y clamp bound.
- STALE_FRAMES, 8, consecutive frames without a gaze sample before reverting to screen centre.
- i_clk  in  1  clock.
- i_rst  in  1  reset, synchronous, active-high.
- i_gaze_valid  in  1  gaze sample valid.
- i_gaze_x  in  11  gaze x, unsigned pixels.
- i_gaze_y  in  11  gaze y, unsigned pixels.
- o_gaze_ready  out  1  scheduler accepts sample when valid && ready.
- i_radius_1 / i_radius_2 / i_radius_3  in  12 each  outer/middle/inner foveal radius, pixels.
- i_sof  in  1  start-of-frame level, same signal the decoder sees.
- i_param_ready  in  1  decoder idle between frames (its WAIT state).
- o_gaze_x / o_gaze_y  out  11  committed gaze.
- o_thres_1 / o_thres_2 / o_thres_3  out  24  committed radius².
- o_update  out  1  one-cycle pulse, outputs changed this cycle.
- o_stale  out  1  gaze timed out, centre in use.

## Operation
- Reset values: o_gaze_x=H_ACTIVE/2 (960), o_gaze_y=V_ACTIVE/2 (540), o_thres_*=0, o_update=0, o_stale=0, o_gaze_ready=0. Pending gaze=centre, stale counter=0.
- Reset mid-operation: abandons any in-flight commit. The committed outputs return to their reset values.
- SOF rise = i_sof && !registered previous i_sof. Delay register resets to 0.
- States: IDLE -> ARM (unconditional, 1 cycle).
  - ARM -> LATCH on SOF rise.
  - LATCH -> SQ0 -> SQ1 -> SQ2 -> WAIT_RDY.
  - WAIT_RDY -> COMMIT when i_param_ready=1.
  - COMMIT -> ARM.
- o_gaze_ready = 1 in every state except IDLE and LATCH.
- An accepted sample clamps x to min(x, H_ACTIVE-1) and y to min(y, V_ACTIVE-1). The clamped values are written to pending gaze.
- LATCH copies pending gaze and i_radius_1..3 into shadow registers. A sample accepted on the same edge as the SOF rise is included.
- SQn: shadow_thres[n] <= radius[n]*radius[n], full 24-bit unsigned, using one shared registered multiplier, one radius per cycle.
- COMMIT: shadow gaze and shadow thresholds become the outputs; o_update=1.
- SOF rises in any state other than ARM are ignored for sequencing: no commit, no queuing.
- Stale counter:
  - On every SOF rise in any state, increments (saturating at STALE_FRAMES) if no sample was accepted since the previous rise.
  - Clears on any accepted sample. An accept coincident with the rise wins.
  - On reaching STALE_FRAMES: pending gaze <= centre and o_stale=1.
  - Next accepted sample clears o_stale.
- Radius ordering is not checked. thres_1 ≥ thres_2 ≥ thres_3 is the integrator's responsibility.

## Timing
- SOF rise sampled at edge k: LATCH after k, SQ0..SQ2 after k+1..k+3, WAIT_RDY after k+4.
- With i_param_ready=1 at edge k+5: outputs update and o_update=1 in the cycle after edge k+5. Minimum latency is 5 clocks.
- If i_param_ready is low, WAIT_RDY holds indefinitely. Commit occurs on the first edge where it is sampled high.
- Outputs are stable for all other cycles. o_update is exactly one cycle wide.
- Sample acceptance: single-cycle, no backpressure other than IDLE and LATCH.

## Configuration
- GAZE_SMOOTH_EN defined: accepted sample updates pending as (pending + clamped + 1) >> 1, computed in 12 bits.
  - Exception: the first sample after reset, or while o_stale=1, loads directly.
- Undefined: pending gaze = clamped sample, and no adder is present.

## Structure
- Shared package fovea_pkg:
  - state enum.
  - defaults for H_ACTIVE/V_ACTIVE and centre constants.
  - GAZE_W=11, RADIUS_W=12, THRES_W=24.
- One sub-module: fovea_squarer.
  - 12-bit input, registered 24-bit square, 1-cycle latency.
  - Instantiated once and time-shared across SQ0..SQ2.

## Test plan
- Reset: hold i_rst 3 cycles -> gaze 960/540, thres 0/0/0, o_update=0, o_stale=0, o_gaze_ready=0.
- Radii 300/200/100, gaze (100,200) accepted, SOF rise, param_ready=1 -> 5 clocks later o_update=1, thres 90000/40000/10000, gaze 100/200.
- param_ready low 20 cycles after SOF -> outputs unchanged; o_update fires one cycle after ready is sampled high. A second SOF rise during the wait causes no extra commit.
- Gaze (2047,1500) -> committed (1919,1079).
- 8 SOF rises with no gaze -> o_stale=1, next commit 960/540. One sample (500,500) -> o_stale=0, next commit 500/500.
- GAZE_SMOOTH_EN: pending 100, sample 201 -> commit 151. Without macro -> 201.
